conv_window_gen: RTL and testbench

- Upstream feeder for the 3x3 convolution stage.
- Accepts a raster-order pixel stream (row-major, one pixel per handshake) and keeps two line buffers plus a 3x3 shift window.
- Presents nine window pixels in parallel for every valid (unpadded) 3x3 position, ready to drive the convolution stage's nine image inputs.
- Handles backpressure with valid/ready on both sides.

---
 rtl/conv_window_gen_pkg.sv | 14 +
 rtl/conv_line_buffer.sv | 17 +
 rtl/conv_window_gen.sv | 129 ++++++++++++
 tb/tb_conv_window_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/conv_window_gen_pkg.sv
// conv_window_gen_pkg: shared defaults, FSM encoding and window index order
package conv_window_gen_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  typedef enum logic [2:0] {IDLE, FILL, RUN, LAST, DONE} state_e;
  localparam int W_TL = 0;
  localparam int W_TC = 1;
  localparam int W_TR = 2;
  localparam int W_ML = 3;
  localparam int W_MC = 4;
  localparam int W_MR = 5;
  localparam int W_BL = 6;
  localparam int W_BC = 7;
  localparam int W_BR = 8;
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: single-port line store, read-before-write at the same address
module conv_line_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 28
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  assign rdata = mem_q[addr];
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixel stream to 3x3 valid-position windows with valid/ready on both sides
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] win0,
  output logic [DATA_WIDTH-1:0] win1,
  output logic [DATA_WIDTH-1:0] win2,
  output logic [DATA_WIDTH-1:0] win3,
  output logic [DATA_WIDTH-1:0] win4,
  output logic [DATA_WIDTH-1:0] win5,
  output logic [DATA_WIDTH-1:0] win6,
  output logic [DATA_WIDTH-1:0] win7,
  output logic [DATA_WIDTH-1:0] win8,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic                  win_last,
  output logic                  frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [DATA_WIDTH-1:0] win_q [9];
  logic [DATA_WIDTH-1:0] win_d [9];
  logic win_valid_q, win_valid_d, win_last_q, win_last_d, frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] top, mid;
  logic accept, consume, qualify, eol, at_end;
  assign pix_ready = !rst && state_q != LAST && state_q != DONE && (!win_valid_q || win_ready);
  assign accept = pix_valid && pix_ready;
  assign consume = win_valid_q && win_ready;
  assign eol = col_q == COL_MAX;
  assign at_end = eol && row_q == ROW_MAX;
  assign qualify = row_q >= RW'(2) && col_q >= CW'(2);
  conv_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb0 (
    .clk(clk), .we(accept), .addr(col_q), .wdata(mid), .rdata(top)
  );
  conv_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb1 (
    .clk(clk), .we(accept), .addr(col_q), .wdata(pix_in), .rdata(mid)
  );
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    win_valid_d = (accept && qualify) ? 1'b1 : (consume ? 1'b0 : win_valid_q);
    win_last_d = (accept && qualify) ? at_end : (consume ? 1'b0 : win_last_q);
    frame_done_d = 1'b0;
    if (accept) begin
      col_d = eol ? '0 : col_q + CW'(1);
      row_d = (eol && row_q != ROW_MAX) ? row_q + RW'(1) : row_q;
      for (int r = 0; r < 3; r++) begin
        win_d[3*r] = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r+2];
      end
      win_d[W_TR] = top;
      win_d[W_MR] = mid;
      win_d[W_BR] = pix_in;
    end
    unique case (state_q)
      IDLE: state_d = accept ? FILL : IDLE;
      FILL: state_d = (accept && row_q == RW'(2) && col_q == CW'(1)) ? RUN : FILL;
      RUN:  state_d = (accept && at_end) ? LAST : RUN;
      LAST: begin
        state_d = consume ? DONE : LAST;
        frame_done_d = consume;
      end
      DONE: begin
        state_d = IDLE;
        col_d = '0;
        row_d = '0;
      end
      default: state_d = IDLE;
    endcase
    // frame abort keeps line buffer contents; the next pixel restarts at (0,0)
    if (clear) begin
      state_d = IDLE;
      col_d = '0;
      row_d = '0;
      win_valid_d = 1'b0;
      win_last_d = 1'b0;
      frame_done_d = 1'b0;
      win_d = '{default: '0};
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      win_q <= '{default: '0};
      win_valid_q <= 1'b0;
      win_last_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      win_q <= win_d;
      win_valid_q <= win_valid_d;
      win_last_q <= win_last_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign win0 = win_q[W_TL];
  assign win1 = win_q[W_TC];
  assign win2 = win_q[W_TR];
  assign win3 = win_q[W_ML];
  assign win4 = win_q[W_MC];
  assign win5 = win_q[W_MR];
  assign win6 = win_q[W_BL];
  assign win7 = win_q[W_BC];
  assign win8 = win_q[W_BR];
  assign win_valid = win_valid_q;
  assign win_last = win_last_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed 4x4 scenarios plus a randomized-handshake 28x28 frame
module tb_conv_window_gen;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic a_clear = 0, a_pix_valid = 0, a_pix_ready, a_win_valid, a_win_ready = 0, a_win_last, a_frame_done;
  logic [15:0] a_pix_in = 0;
  logic [15:0] a_w [9];
  logic b_clear = 0, b_pix_valid = 0, b_pix_ready, b_win_valid, b_win_ready = 0, b_win_last, b_frame_done;
  logic [15:0] b_pix_in = 0;
  logic [15:0] b_w [9];
  conv_window_gen #(.DATA_WIDTH(16), .IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .rst(rst), .clear(a_clear), .pix_in(a_pix_in), .pix_valid(a_pix_valid),
    .pix_ready(a_pix_ready), .win0(a_w[0]), .win1(a_w[1]), .win2(a_w[2]), .win3(a_w[3]),
    .win4(a_w[4]), .win5(a_w[5]), .win6(a_w[6]), .win7(a_w[7]), .win8(a_w[8]),
    .win_valid(a_win_valid), .win_ready(a_win_ready), .win_last(a_win_last), .frame_done(a_frame_done)
  );
  conv_window_gen dut_b (
    .clk(clk), .rst(rst), .clear(b_clear), .pix_in(b_pix_in), .pix_valid(b_pix_valid),
    .pix_ready(b_pix_ready), .win0(b_w[0]), .win1(b_w[1]), .win2(b_w[2]), .win3(b_w[3]),
    .win4(b_w[4]), .win5(b_w[5]), .win6(b_w[6]), .win7(b_w[7]), .win8(b_w[8]),
    .win_valid(b_win_valid), .win_ready(b_win_ready), .win_last(b_win_last), .frame_done(b_frame_done)
  );
  int total = 0, bad = 0;
  int cyc = 0, a_idx = 0, a_n = 16, a_fd = 0, fd_cyc = -1, hold_n = 0, last_seen = 0;
  logic [15:0] a_src [64];
  logic [143:0] wq[$];
  bit lq[$];
  int cq[$];
  logic [15:0] b_src [784];
  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [143:0] pack_a();
    return {a_w[0], a_w[1], a_w[2], a_w[3], a_w[4], a_w[5], a_w[6], a_w[7], a_w[8]};
  endfunction
  function automatic logic [143:0] pack_b();
    return {b_w[0], b_w[1], b_w[2], b_w[3], b_w[4], b_w[5], b_w[6], b_w[7], b_w[8]};
  endfunction
  function automatic logic [143:0] exp4(input int off, input int r, input int c);
    logic [143:0] v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) v = {v[127:0], 16'(off + (r - 2 + i) * 4 + (c - 2 + j) + 1)};
    return v;
  endfunction
  function automatic logic [143:0] expb(input int k);
    logic [143:0] v = '0;
    int r = 2 + k / 26, c = 2 + k % 26;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) v = {v[127:0], b_src[(r - 2 + i) * 28 + (c - 2 + j)]};
    return v;
  endfunction
  task automatic new_frame();
    wq.delete(); lq.delete(); cq.delete();
    a_idx = 0; a_fd = 0; fd_cyc = -1; hold_n = 0; last_seen = 0;
  endtask
  task automatic step_a(input int mode);
    bit hold;
    @(negedge clk);
    hold = mode == 1 && a_win_valid && wq.size() == 1 && hold_n < 5;
    a_win_ready = mode == 1 ? !hold : (mode == 2 ? !(a_win_valid && a_win_last) : 1'b1);
    a_pix_valid = a_idx < a_n;
    a_pix_in = a_idx < a_n ? a_src[a_idx] : 16'h0;
    #1;
    if (hold) begin
      chk("hold_win", pack_a(), exp4(0, 2, 3));
      chk("hold_pix_ready", 144'(a_pix_ready), 144'(0));
      hold_n++;
    end
    if (a_frame_done) begin a_fd++; fd_cyc = cyc; end
    if (a_win_valid && a_win_last) last_seen++;
    if (a_pix_valid && a_pix_ready) a_idx++;
    if (a_win_valid && a_win_ready) begin
      wq.push_back(pack_a()); lq.push_back(a_win_last); cq.push_back(cyc);
    end
    cyc++;
  endtask
  task automatic run_a(input int mode, input int target);
    int c0 = cyc;
    while (a_fd < target && cyc - c0 < 300) step_a(mode);
    repeat (3) step_a(mode);
    chk("frame_done_count", 144'(a_fd), 144'(target));
  endtask
  task automatic chk_frame4(input int off, input int k0);
    for (int i = 0; i < 4; i++) begin
      chk("win", wq.size() > k0 + i ? wq[k0 + i] : '1, exp4(off, 2 + i / 2, 2 + i % 2));
      chk("win_last", wq.size() > k0 + i ? 144'(lq[k0 + i]) : '1, 144'(i == 3));
    end
  endtask
  initial begin
    int kidx = 0, b_idx = 0, b_fd = 0, b_lasts = 0, bc = 0;
    for (int i = 0; i < 64; i++) a_src[i] = 16'(i < 16 ? i + 1 : 101 + (i - 16));
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pix_ready", 144'(a_pix_ready), 144'(0));
    chk("rst_win_valid", 144'(a_win_valid), 144'(0));
    chk("rst_flags", 144'({a_win_last, a_frame_done}), 144'(0));
    chk("rst_win", pack_a(), 144'(0));
    @(negedge clk); rst = 0;
    // basic 4x4 frame, always ready
    new_frame(); run_a(0, 1);
    chk("n_win", 144'(wq.size()), 144'(4));
    chk_frame4(0, 0);
    chk("done_timing", 144'(fd_cyc), 144'(cq.size() == 4 ? cq[3] + 1 : -5));
    // backpressure on the second window
    new_frame(); run_a(1, 1);
    chk("hold_cycles", 144'(hold_n), 144'(5));
    chk("bp_n_win", 144'(wq.size()), 144'(4));
    chk_frame4(0, 0);
    // async reset mid-frame after pixel 7
    new_frame();
    while (a_idx < 7 && cyc < 2000) step_a(0);
    @(posedge clk); #2; rst = 1; a_pix_valid = 0; #1;
    chk("mid_rst_pix_ready", 144'(a_pix_ready), 144'(0));
    chk("mid_rst_flags", 144'({a_win_valid, a_win_last, a_frame_done}), 144'(0));
    chk("mid_rst_win", pack_a(), 144'(0));
    @(negedge clk); rst = 0;
    new_frame(); run_a(0, 1);
    chk("rerun_n_win", 144'(wq.size()), 144'(4));
    chk_frame4(0, 0);
    // clear while the last window is stalled
    new_frame();
    begin
      int c0 = cyc;
      while (last_seen < 2 && cyc - c0 < 300) step_a(2);
    end
    chk("pre_clear_n_win", 144'(wq.size()), 144'(3));
    @(negedge clk); a_clear = 1; a_win_ready = 0; a_pix_valid = 0;
    @(negedge clk); a_clear = 0; #1;
    chk("clear_flags", 144'({a_win_valid, a_win_last, a_frame_done}), 144'(0));
    repeat (3) step_a(0);
    chk("clear_no_done", 144'(a_fd), 144'(0));
    new_frame(); run_a(0, 1);
    chk_frame4(0, 0);
    // two frames back to back
    new_frame(); a_n = 32; run_a(0, 2);
    chk("b2b_n_win", 144'(wq.size()), 144'(8));
    chk_frame4(0, 0);
    chk_frame4(100, 4);
    chk("tput_f1", 144'(cq.size() > 1 ? cq[1] - cq[0] : 0), 144'(1));
    chk("tput_f2", 144'(cq.size() > 5 ? cq[5] - cq[4] : 0), 144'(1));
    a_n = 16;
    // full-size frame with random handshakes
    for (int i = 0; i < 784; i++) b_src[i] = 16'($urandom);
    b_src[5] = 16'hFFFF; b_src[56] = 16'h8000; b_src[58] = 16'hFFFF;
    b_src[400] = 16'h8000; b_src[783] = 16'hFFFF;
    while (b_fd == 0 && bc < 20000) begin
      @(negedge clk);
      b_win_ready = 1'($urandom_range(0, 1));
      b_pix_valid = b_idx < 784 && $urandom_range(0, 1) == 1;
      b_pix_in = b_idx < 784 ? b_src[b_idx] : 16'h0;
      #1;
      if (b_frame_done) b_fd++;
      if (b_pix_valid && b_pix_ready) b_idx++;
      if (b_win_valid && b_win_ready) begin
        if (kidx < 676) chk("b_win", pack_b(), expb(kidx));
        chk("b_last", 144'(b_win_last), 144'(kidx == 675));
        if (b_win_last) b_lasts++;
        kidx++;
      end
      bc++;
    end
    repeat (4) begin
      @(negedge clk); #1;
      if (b_frame_done) b_fd++;
    end
    chk("b_n_win", 144'(kidx), 144'(676));
    chk("b_lasts", 144'(b_lasts), 144'(1));
    chk("b_frame_done", 144'(b_fd), 144'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
